seg_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the 4-digit seven-segment display. It generates the 2-bit digit select that drives the select input of the 4-to-1 4-bit nibble mux, and the matching active-low anode enables. It inserts a programmable dead time at the start of each digit slot to suppress ghosting, and emits a per-frame tick for downstream refresh logic. It sits directly upstream of the nibble mux; the mux output feeds the seven-segment decoder.

---
 rtl/seg_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexing scan controller for a 4-digit seven-segment display.
//
// Each digit owns a slot of PRESCALE clock cycles. The first DEAD cycles of
// every slot are blank, so the downstream nibble mux can settle on the new
// digit before that digit's anode turns on. A one-cycle frame_tick marks the
// first cycle of digit 0's slot, once per four slots.
//
// Optional feature, enabled by defining SEG_SCAN_BLINK_EN:
//   Adds the blink_mask port and the BLINK_DIV parameter. Frame ticks are
//   counted 0..BLINK_DIV-1. Each time that count wraps, a blink phase bit
//   toggles. While the phase is 1, every digit selected in blink_mask stays
//   dark.
//
// Parameters:
//   PRESCALE   clock cycles per digit slot (>= 2)
//   DEAD       blank cycles at the start of each slot (0 <= DEAD < PRESCALE)
//   BLINK_DIV  frames per blink half-period (>= 1), SEG_SCAN_BLINK_EN only
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   en          scan enable; low freezes the scan and blanks all anodes
//   digit_en    per-digit enable mask; bit i = 0 keeps anode i off
//   blink_mask  per-digit blink select (SEG_SCAN_BLINK_EN only)
//   sel         digit select for the nibble mux (0 = a .. 3 = d)
//   an          active-low anode enables; bit i drives digit i
//   frame_tick  one-cycle pulse on the first cycle of each new frame
//
// All outputs are registered. an and frame_tick are computed from the same
// next-state values that are loaded into cnt/sel. This keeps every output
// consistent with the slot position in every cycle.
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int PRESCALE  = 50000,
    parameter int DEAD      = 500
`ifdef SEG_SCAN_BLINK_EN
    ,
    parameter int BLINK_DIV = 32
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_en,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [3:0] blink_mask,
`endif
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nx_s;
    logic [1:0]    sel_r;
    logic [1:0]    sel_nx_s;
    logic [3:0]    an_r;
    logic [3:0]    an_nx_s;
    logic          tick_r;
    logic          tick_nx_s;
    logic [3:0]    hide_s;
    logic [3:0]    visible_s;

    // Anode pattern for a slot position. The result is blank during dead
    // time or when the digit is not visible; otherwise exactly one bit is low.
    function automatic logic [3:0] anode_decode(
        input logic [CW-1:0] c,
        input logic [1:0]    s,
        input logic [3:0]    vis
    );
        logic [3:0] a;
        a = 4'b1111;
        if (c < CW'(DEAD)) begin
            a = 4'b1111;
        end else if (vis[s]) begin
            case (s)
                2'd0:    a = 4'b1110;
                2'd1:    a = 4'b1101;
                2'd2:    a = 4'b1011;
                2'd3:    a = 4'b0111;
                default: a = 4'b1111;
            endcase
        end else begin
            a = 4'b1111;
        end
        return a;
    endfunction

`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt_r;
    logic [BW-1:0] blink_cnt_nx_s;
    logic          blink_ph_r;
    logic          blink_ph_nx_s;

    // The blink counter advances on frame ticks only. Its wrap flips the
    // phase. The phase update happens on the same edge that starts the frame.
    always_comb begin
        blink_cnt_nx_s = blink_cnt_r;
        blink_ph_nx_s  = blink_ph_r;
        if (tick_nx_s) begin
            if (blink_cnt_r == BW'(BLINK_DIV - 1)) begin
                blink_cnt_nx_s = BW'(0);
                blink_ph_nx_s  = ~blink_ph_r;
            end else begin
                blink_cnt_nx_s = blink_cnt_r + BW'(1);
            end
        end else begin
            blink_cnt_nx_s = blink_cnt_r;
        end
    end

    // Blink counter and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_r <= BW'(0);
            blink_ph_r  <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_nx_s;
            blink_ph_r  <= blink_ph_nx_s;
        end
    end

    // The next phase is used so that the anodes loaded on this edge match
    // the frame that starts on this edge.
    always_comb begin
        if (blink_ph_nx_s) begin
            hide_s = blink_mask;
        end else begin
            hide_s = 4'b0000;
        end
    end
`else
    // Without blinking, no digit is ever hidden.
    always_comb begin
        hide_s = 4'b0000;
    end
`endif

    // Effective visibility mask for the anodes loaded on this edge.
    always_comb begin
        visible_s = digit_en & ~hide_s;
    end

    // Scan step: advance the slot counter, move to the next digit on wrap,
    // and derive the registered anode pattern and frame tick.
    always_comb begin
        cnt_nx_s  = cnt_r;
        sel_nx_s  = sel_r;
        tick_nx_s = 1'b0;
        an_nx_s   = 4'b1111;
        if (en) begin
            if (cnt_r == CW'(PRESCALE - 1)) begin
                cnt_nx_s = CW'(0);
                sel_nx_s = sel_r + 2'd1;
                if (sel_r == 2'd3) begin
                    tick_nx_s = 1'b1;
                end else begin
                    tick_nx_s = 1'b0;
                end
            end else begin
                cnt_nx_s = cnt_r + CW'(1);
            end
            an_nx_s = anode_decode(cnt_nx_s, sel_nx_s, visible_s);
        end else begin
            // Frozen: counters hold, display blank, no tick.
            an_nx_s   = 4'b1111;
            tick_nx_s = 1'b0;
        end
    end

    // Scan state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= CW'(0);
            sel_r  <= 2'd0;
            an_r   <= 4'b1111;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nx_s;
            sel_r  <= sel_nx_s;
            an_r   <= an_nx_s;
            tick_r <= tick_nx_s;
        end
    end

    assign sel        = sel_r;
    assign an         = an_r;
    assign frame_tick = tick_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//
// The reference model tracks how many enabled clock edges have occurred since
// reset (p). The expected outputs follow from p by plain arithmetic:
//   slot position = p % 8
//   digit         = (p / 8) % 4
//   frame         = p / 32
//   blink phase   = (frame / 2) % 2
// The model also holds the inputs seen at the last edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int PS = 8;
    localparam int DT = 2;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] digit_en = 4'b1111;
    logic [3:0] blink_mask = 4'b0000;
    logic [1:0] sel;
    logic [3:0] an;
    logic       frame_tick;

    int total = 0;
    int bad = 0;

    // Reference model state
    int         p = 0;
    logic       m_en = 1'b0;
    logic       m_inc = 1'b0;
    logic [3:0] m_de = 4'b1111;
    logic [3:0] m_bm = 4'b0000;

`ifdef SEG_SCAN_BLINK_EN
    seg_scan_ctrl #(.PRESCALE(PS), .DEAD(DT), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .en(en), .digit_en(digit_en),
        .blink_mask(blink_mask),
        .sel(sel), .an(an), .frame_tick(frame_tick)
    );
`else
    seg_scan_ctrl #(.PRESCALE(PS), .DEAD(DT)) dut (
        .clk(clk), .rst(rst), .en(en), .digit_en(digit_en),
        .sel(sel), .an(an), .frame_tick(frame_tick)
    );
`endif

    always #5 clk = ~clk;

    function automatic logic [1:0] exp_sel();
        return 2'((p / PS) % 4);
    endfunction

    function automatic int blink_phase();
`ifdef SEG_SCAN_BLINK_EN
        return ((p / (4 * PS)) / BD) % 2;
`else
        return 0;
`endif
    endfunction

    function automatic logic [3:0] exp_an();
        int s;
        int pos;
        logic [3:0] one;
        s = (p / PS) % 4;
        pos = p % PS;
        one = 4'b0001;
        if (!m_en || pos < DT) return 4'b1111;
        if (m_de[s] && !(blink_phase() == 1 && m_bm[s])) return ~(one << s);
        return 4'b1111;
    endfunction

    function automatic logic exp_tick();
        return m_inc && (p > 0) && ((p % (4 * PS)) == 0);
    endfunction

    // Drive inputs, advance one edge, update the model, then land on the
    // following negedge, where outputs are sampled.
    task automatic step(input logic e, input logic [3:0] de, input logic [3:0] bm);
        en = e;
        digit_en = de;
        blink_mask = bm;
        @(posedge clk);
        m_inc = e;
        m_en = e;
        m_de = de;
        m_bm = bm;
        if (e) p = p + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        p = 0;
        m_en = 1'b0;
        m_inc = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (sel !== 2'd0 || an !== 4'b1111 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL reset_state sel=%0d an=%b tick=%b want 0/1111/0", sel, an, frame_tick);
        end
    endtask

    task automatic test_basic_scan();
        int ticks;
        do_reset();
        ticks = 0;
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 4'b1111, 4'b0000);
            if (frame_tick === 1'b1) ticks++;
            total++;
            if (sel !== exp_sel() || an !== exp_an() || frame_tick !== exp_tick()) begin
                bad++;
                $display("FAIL basic_model k=%0d sel=%0d/%0d an=%b/%b tick=%b/%b",
                         k, sel, exp_sel(), an, exp_an(), frame_tick, exp_tick());
            end
            if (k >= 2 && k <= 7) begin
                total++;
                if (an !== 4'b1110) begin
                    bad++;
                    $display("FAIL basic_slot0 k=%0d an=%b want 1110", k, an);
                end
            end
            if (k == 8) begin
                total++;
                if (sel !== 2'd1) begin
                    bad++;
                    $display("FAIL basic_sel1 sel=%0d want 1", sel);
                end
            end
            if (k == 32) begin
                total++;
                if (sel !== 2'd0 || frame_tick !== 1'b1 || ticks != 1) begin
                    bad++;
                    $display("FAIL basic_frame sel=%0d tick=%b ticks=%0d want 0/1/1", sel, frame_tick, ticks);
                end
            end
        end
    endtask

    task automatic test_digit_mask();
        do_reset();
        for (int k = 1; k <= 32; k++) begin
            step(1'b1, 4'b1010, 4'b0000);
            total++;
            if (sel !== exp_sel() || an !== exp_an() || frame_tick !== exp_tick()) begin
                bad++;
                $display("FAIL mask_model k=%0d sel=%0d/%0d an=%b/%b tick=%b/%b",
                         k, sel, exp_sel(), an, exp_an(), frame_tick, exp_tick());
            end
            if ((k < 8 || (k >= 16 && k < 24)) && an !== 4'b1111) begin
                bad++;
                $display("FAIL mask_blank k=%0d an=%b want 1111", k, an);
            end
            if (k >= 10 && k <= 15 && an !== 4'b1101) begin
                bad++;
                $display("FAIL mask_d1 k=%0d an=%b want 1101", k, an);
            end
        end
    endtask

    task automatic test_en_pause();
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            step((k >= 13 && k <= 20) ? 1'b0 : 1'b1, 4'b1111, 4'b0000);
            total++;
            if (sel !== exp_sel() || an !== exp_an() || frame_tick !== exp_tick()) begin
                bad++;
                $display("FAIL pause_model k=%0d sel=%0d/%0d an=%b/%b tick=%b/%b",
                         k, sel, exp_sel(), an, exp_an(), frame_tick, exp_tick());
            end
            if (k >= 13 && k <= 20 && (an !== 4'b1111 || sel !== 2'd1)) begin
                bad++;
                $display("FAIL pause_hold k=%0d an=%b sel=%0d want 1111/1", k, an, sel);
            end
            if (k == 23 && sel !== 2'd1) begin
                bad++;
                $display("FAIL pause_resume23 sel=%0d want 1", sel);
            end
            if (k == 24 && sel !== 2'd2) begin
                bad++;
                $display("FAIL pause_resume24 sel=%0d want 2", sel);
            end
        end
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        for (int k = 1; k <= 29; k++) step(1'b1, 4'b1111, 4'b0000);
        total++;
        if (an !== 4'b0111 || sel !== 2'd3) begin
            bad++;
            $display("FAIL midrst_pre an=%b sel=%0d want 0111/3", an, sel);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (sel !== 2'd0 || an !== 4'b1111 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL midrst_async sel=%0d an=%b tick=%b want 0/1111/0", sel, an, frame_tick);
        end
        @(negedge clk);
        rst = 1'b0;
        p = 0;
        m_en = 1'b0;
        m_inc = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 4'b1111, 4'b0000);
            total++;
            if (sel !== exp_sel() || an !== exp_an() || frame_tick !== exp_tick()) begin
                bad++;
                $display("FAIL midrst_model k=%0d sel=%0d/%0d an=%b/%b tick=%b/%b",
                         k, sel, exp_sel(), an, exp_an(), frame_tick, exp_tick());
            end
            if (k == 1 && an !== 4'b1111) begin
                bad++;
                $display("FAIL midrst_dead an=%b want 1111", an);
            end
            if (k == 2 && (an !== 4'b1110 || sel !== 2'd0)) begin
                bad++;
                $display("FAIL midrst_first an=%b sel=%0d want 1110/0", an, sel);
            end
        end
    endtask

    task automatic test_blink();
        logic [3:0] want;
        do_reset();
        for (int k = 1; k <= 6 * 4 * PS; k++) begin
            step(1'b1, 4'b1111, 4'b0001);
            total++;
            if (sel !== exp_sel() || an !== exp_an() || frame_tick !== exp_tick()) begin
                bad++;
                $display("FAIL blink_model k=%0d sel=%0d/%0d an=%b/%b tick=%b/%b",
                         k, sel, exp_sel(), an, exp_an(), frame_tick, exp_tick());
            end
            if ((k % (4 * PS)) >= DT && (k % (4 * PS)) < PS) begin
`ifdef SEG_SCAN_BLINK_EN
                want = (((k / (4 * PS)) / 2) % 2 == 1) ? 4'b1111 : 4'b1110;
`else
                want = 4'b1110;
`endif
                if (an !== want) begin
                    bad++;
                    $display("FAIL blink_d0 k=%0d frame=%0d an=%b want %b", k, k / (4 * PS), an, want);
                end
            end
        end
    endtask

    task automatic test_random();
        logic e;
        logic [3:0] de;
        logic [3:0] bm;
        do_reset();
        de = 4'b1111;
        bm = 4'b0000;
        for (int k = 1; k <= 600; k++) begin
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) de = 4'($urandom);
            if ($urandom_range(0, 20) == 0) bm = 4'($urandom);
            step(e, de, bm);
            total++;
            if (sel !== exp_sel() || an !== exp_an() || frame_tick !== exp_tick()) begin
                bad++;
                $display("FAIL random_model k=%0d sel=%0d/%0d an=%b/%b tick=%b/%b",
                         k, sel, exp_sel(), an, exp_an(), frame_tick, exp_tick());
            end
            if ($countones(~an) > 1) begin
                bad++;
                $display("FAIL random_onehot k=%0d an=%b want at most one low", k, an);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_scan();
        test_digit_mask();
        test_en_pause();
        test_reset_mid_slot();
        test_blink();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
